// File: rtl/cursor_pkg.sv
// cursor_pkg
//   Shared definitions for the joystick cursor controller:
//     - dir_t        : per-axis stick direction (DIR_NEG / DIR_POS)
//     - DEF_*        : default centre, deadzone, step shift and accumulator full-scale
//     - EDGE_*       : bit positions inside the at_edge flag vector
//     - RUN_*        : run-counter width and the run length at which moves double
//     - accWidth()   : width needed to hold an accumulator value 0..accMax
//   Optional feature macro used by the importing modules: CURSOR_ACCEL_EN.
package cursor_pkg;

    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_t;

    localparam int DEF_CENTER   = 512;
    localparam int DEF_DEADZONE = 16;
    localparam int DEF_SHIFT    = 4;
    localparam int DEF_ACC_MAX  = 31;

    localparam int EDGE_X_MIN = 0;
    localparam int EDGE_X_MAX = 1;
    localparam int EDGE_Y_MIN = 2;
    localparam int EDGE_Y_MAX = 3;

    localparam int RUN_W    = 4;
    localparam int RUN_FAST = 8;

    function automatic int accWidth(input int accMax);
        return $clog2(accMax + 1);
    endfunction

endpackage

// File: rtl/cursor_axis.sv
// cursor_axis
//   One cursor axis: rate accumulator, last-direction register, position
//   register with clamp or wrap at 0/MAX, and (with CURSOR_ACCEL_EN) a run
//   counter that doubles the move size after RUN_FAST consecutive moves.
//   Parameters: POS_W, MAX, RST, INVERT (1 = positive stick moves toward 0), ACC_MAX.
//   Ports:
//     clk50, nreset      clock and synchronous active-low reset
//     tick               update enable; state only changes on tick
//     recenter           forces position to RST and clears the accumulator
//     idle               both axes inside the deadzone
//     wrapMode           0 = clamp at bounds, 1 = wrap around
//     dir, step          this axis's stick direction and accumulator increment
//     pos                current coordinate
//     changeNext         this tick will change pos (combinational, tick-qualified)
//   Optional feature macro: CURSOR_ACCEL_EN.
module cursor_axis
    import cursor_pkg::*;
#(
    parameter int POS_W   = 10,
    parameter int MAX     = 159,
    parameter int RST     = 79,
    parameter bit INVERT  = 1'b0,
    parameter int ACC_MAX = DEF_ACC_MAX,
    parameter int ACC_W   = accWidth(ACC_MAX)
) (
    input  logic             clk50,
    input  logic             nreset,
    input  logic             tick,
    input  logic             recenter,
    input  logic             idle,
    input  logic             wrapMode,
    input  dir_t             dir,
    input  logic [ACC_W-1:0] step,
    output logic [POS_W-1:0] pos,
    output logic             changeNext
);

    localparam int AW1 = ACC_W + 1;

    localparam logic [POS_W-1:0] LIM        = POS_W'(MAX);
    localparam logic [POS_W-1:0] RST_POS    = POS_W'(RST);
    localparam logic [POS_W-1:0] ONE        = POS_W'(1);
    localparam logic [ACC_W-1:0] ACC_FULL   = ACC_W'(ACC_MAX);
    localparam logic [AW1-1:0]   ACC_FULL_W = AW1'(ACC_MAX);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] accNext;
    logic [AW1-1:0]   accSum;
    logic [POS_W-1:0] posNext;
    logic [POS_W-1:0] target;
    logic [POS_W-1:0] amount;
    logic [POS_W-1:0] headroom;
    logic             moveUp;
    dir_t             lastDir;

`ifdef CURSOR_ACCEL_EN
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] runNext;
`endif

    // Candidate position for a move, then the priority chain:
    // recenter > idle > reversal > move when full > accumulate.
    // Overflow is detected from the room left to the bound so that all
    // arithmetic stays POS_W wide; pos is always within 0..MAX.
    always_comb begin
        amount = ONE;
`ifdef CURSOR_ACCEL_EN
        runNext = run;
        if (run >= RUN_W'(RUN_FAST)) begin
            amount = POS_W'(2);
        end
`endif
        moveUp   = (dir == DIR_POS) ^ INVERT;
        headroom = LIM - pos;
        target   = pos;
        if (moveUp) begin
            if (headroom < amount) begin
                target = wrapMode ? (amount - headroom - ONE) : LIM;
            end else begin
                target = pos + amount;
            end
        end else begin
            if (pos < amount) begin
                target = wrapMode ? (LIM - (amount - pos - ONE)) : '0;
            end else begin
                target = pos - amount;
            end
        end

        accSum  = {1'b0, acc} + {1'b0, step};
        accNext = acc;
        posNext = pos;

        if (recenter) begin
            posNext = RST_POS;
            accNext = '0;
`ifdef CURSOR_ACCEL_EN
            runNext = '0;
`endif
        end else if (idle) begin
`ifdef CURSOR_ACCEL_EN
            runNext = '0;
`endif
        end else if (dir != lastDir) begin
            accNext = '0;
`ifdef CURSOR_ACCEL_EN
            runNext = '0;
`endif
        end else if (acc >= ACC_FULL) begin
            accNext = '0;
            posNext = target;
`ifdef CURSOR_ACCEL_EN
            if (run != '1) begin
                runNext = run + 1'b1;
            end
`endif
        end else begin
            accNext = (accSum >= ACC_FULL_W) ? ACC_FULL : accSum[ACC_W-1:0];
        end
    end

    assign changeNext = tick && (posNext != pos);

    // Axis state; direction is latched on every tick so a reversal is seen
    // even across idle or recenter ticks.
    always_ff @(posedge clk50) begin
        if (!nreset) begin
            pos     <= RST_POS;
            acc     <= '0;
            lastDir <= DIR_POS;
`ifdef CURSOR_ACCEL_EN
            run     <= '0;
`endif
        end else if (tick) begin
            pos     <= posNext;
            acc     <= accNext;
            lastDir <= dir;
`ifdef CURSOR_ACCEL_EN
            run     <= runNext;
`endif
        end
    end

endmodule

// File: rtl/joystick_cursor_ctrl.sv
// joystick_cursor_ctrl
//   Converts two raw joystick ADC samples into a bounded 2-D cursor position
//   with rate-proportional motion, optional wrap-around, edge flags and a
//   one-cycle move strobe. Updates happen only on the tick enable.
//   Ports:
//     clk50      system clock
//     nreset     synchronous active-low reset
//     tick       one-cycle update enable
//     recenter   on tick, returns the cursor to X_RST/Y_RST
//     wrap_mode  0 = clamp at bounds, 1 = wrap around
//     adc_x/y    raw unsigned ADC samples
//     mouse_x/y  cursor coordinates
//     moved      pulse the cycle after a tick that changed either coordinate
//     at_edge    {y_max, y_min, x_max, x_min} position-on-bound flags
//   Optional feature macro: CURSOR_ACCEL_EN (double-size moves after a run of 8).
module joystick_cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int ADC_W    = 11,
    parameter int CENTER   = DEF_CENTER,
    parameter int POS_W    = 10,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int X_RST    = 79,
    parameter int Y_RST    = 59,
    parameter int DEADZONE = DEF_DEADZONE,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int ACC_MAX  = DEF_ACC_MAX
) (
    input  logic             clk50,
    input  logic             nreset,
    input  logic             tick,
    input  logic             recenter,
    input  logic             wrap_mode,
    input  logic [ADC_W-1:0] adc_x,
    input  logic [ADC_W-1:0] adc_y,
    output logic [POS_W-1:0] mouse_x,
    output logic [POS_W-1:0] mouse_y,
    output logic             moved,
    output logic [3:0]       at_edge
);

    localparam int AW    = ADC_W + 1;
    localparam int ACC_W = accWidth(ACC_MAX);

    localparam logic signed [AW-1:0] CENTER_S = AW'(CENTER);
    localparam logic [AW-1:0]        DZ       = AW'(DEADZONE);
    localparam logic [AW-1:0]        STEP_CAP = AW'(ACC_MAX);
    localparam logic [POS_W-1:0]     X_LIM    = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]     Y_LIM    = POS_W'(Y_MAX);

    logic signed [AW-1:0] deltaX;
    logic signed [AW-1:0] deltaY;
    logic [AW-1:0]        magX;
    logic [AW-1:0]        magY;
    logic [AW-1:0]        shiftX;
    logic [AW-1:0]        shiftY;
    logic [ACC_W-1:0]     stepX;
    logic [ACC_W-1:0]     stepY;
    dir_t                 dirX;
    dir_t                 dirY;
    logic                 idle;
    logic                 changeX;
    logic                 changeY;

    // Signed offset from centre, its sign as direction, its magnitude, and a
    // saturated per-tick step; the sample is zero-extended so it never reads
    // as negative.
    always_comb begin
        deltaX = $signed({1'b0, adc_x}) - CENTER_S;
        deltaY = $signed({1'b0, adc_y}) - CENTER_S;
        dirX   = deltaX[AW-1] ? DIR_NEG : DIR_POS;
        dirY   = deltaY[AW-1] ? DIR_NEG : DIR_POS;
        magX   = deltaX[AW-1] ? unsigned'(-deltaX) : unsigned'(deltaX);
        magY   = deltaY[AW-1] ? unsigned'(-deltaY) : unsigned'(deltaY);
        shiftX = magX >> SHIFT;
        shiftY = magY >> SHIFT;
        stepX  = (shiftX > STEP_CAP) ? ACC_W'(ACC_MAX) : shiftX[ACC_W-1:0];
        stepY  = (shiftY > STEP_CAP) ? ACC_W'(ACC_MAX) : shiftY[ACC_W-1:0];
        idle   = (magX < DZ) && (magY < DZ);
    end

    cursor_axis #(
        .POS_W  (POS_W),
        .MAX    (X_MAX),
        .RST    (X_RST),
        .INVERT (1'b0),
        .ACC_MAX(ACC_MAX),
        .ACC_W  (ACC_W)
    ) axisX (
        .clk50     (clk50),
        .nreset    (nreset),
        .tick      (tick),
        .recenter  (recenter),
        .idle      (idle),
        .wrapMode  (wrap_mode),
        .dir       (dirX),
        .step      (stepX),
        .pos       (mouse_x),
        .changeNext(changeX)
    );

    // Y is screen-down positive, so a stick pushed up moves toward 0.
    cursor_axis #(
        .POS_W  (POS_W),
        .MAX    (Y_MAX),
        .RST    (Y_RST),
        .INVERT (1'b1),
        .ACC_MAX(ACC_MAX),
        .ACC_W  (ACC_W)
    ) axisY (
        .clk50     (clk50),
        .nreset    (nreset),
        .tick      (tick),
        .recenter  (recenter),
        .idle      (idle),
        .wrapMode  (wrap_mode),
        .dir       (dirY),
        .step      (stepY),
        .pos       (mouse_y),
        .changeNext(changeY)
    );

    // Move strobe: the axis change flags are already qualified by tick, so
    // this is high only for the cycle after a position-changing tick.
    always_ff @(posedge clk50) begin
        if (!nreset) begin
            moved <= 1'b0;
        end else begin
            moved <= changeX | changeY;
        end
    end

    always_comb begin
        at_edge             = '0;
        at_edge[EDGE_X_MIN] = (mouse_x == '0);
        at_edge[EDGE_X_MAX] = (mouse_x == X_LIM);
        at_edge[EDGE_Y_MIN] = (mouse_y == '0);
        at_edge[EDGE_Y_MAX] = (mouse_y == Y_LIM);
    end

endmodule
